// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared types and sizes for the fetch/decode pipeline
package cpu_defs_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fifo_entry_t;
  localparam int INST_FIFO_DEPTH = 16;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: dual-issue fall-through instruction queue between fetch and decode
module inst_fifo
  import cpu_defs_pkg::*;
#(
  parameter  int DEPTH = INST_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_addr1,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_addr2,
  input  logic [31:0] write_inst2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_addr1,
  output logic [31:0] read_inst1,
  output logic [31:0] read_addr2,
  output logic [31:0] read_inst2,
  output logic        empty,
  output logic        almost_empty,
  output logic        fifo_full
);
  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, n_wr, n_rd;
  logic          wr1, wr2, rd1, rd2;
  fifo_entry_t   head, next;
  // a pair is only accepted when room for both slots is guaranteed, so full blocks all writes
  assign wr1  = write_en1 && !fifo_full;
  assign wr2  = wr1 && write_en2;
  assign rd1  = read_en1 && (count != '0);
  assign rd2  = rd1 && read_en2 && (count >= (AW+1)'(2));
  assign n_wr = (AW+1)'(wr1) + (AW+1)'(wr2);
  assign n_rd = (AW+1)'(rd1) + (AW+1)'(rd2);
  assign head = mem[rd_ptr];
  assign next = mem[rd_ptr + AW'(1)];
  assign read_addr1   = (count != '0) ? head.addr : '0;
  assign read_inst1   = (count != '0) ? head.inst : '0;
  assign read_addr2   = (count >= (AW+1)'(2)) ? next.addr : '0;
  assign read_inst2   = (count >= (AW+1)'(2)) ? next.inst : '0;
  assign empty        = (count == '0);
  assign almost_empty = (count == (AW+1)'(1));
  assign fifo_full    = (count >= (AW+1)'(DEPTH - 1));
  // storage is not reset; flushed-cycle writes are discarded
  always_ff @(posedge clk) begin
    if (!flush && wr1) mem[wr_ptr] <= '{addr: write_addr1, inst: write_inst1};
    if (!flush && wr2) mem[wr_ptr + AW'(1)] <= '{addr: write_addr2, inst: write_inst2};
  end
  // pointers wrap naturally at DEPTH; flush beats push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_wr[AW-1:0];
      rd_ptr <= rd_ptr + n_rd[AW-1:0];
      count  <= count + n_wr - n_rd;
    end
  end
endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo: randomized self-checking bench for inst_fifo against a queue model
module tb_inst_fifo;
  logic        clk = 0, rst = 1, flush = 0;
  logic        we1 = 0, we2 = 0, re1 = 0, re2 = 0;
  logic [31:0] wa1 = 0, wi1 = 0, wa2 = 0, wi2 = 0;
  logic [31:0] ra1, ri1, ra2, ri2;
  logic        empty, almost_empty, fifo_full;
  int          checks = 0, failures = 0;
  logic [63:0] q[$];

  inst_fifo dut (
    .clk(clk), .rst(rst), .flush(flush),
    .write_en1(we1), .write_en2(we2),
    .write_addr1(wa1), .write_inst1(wi1), .write_addr2(wa2), .write_inst2(wi2),
    .read_en1(re1), .read_en2(re2),
    .read_addr1(ra1), .read_inst1(ri1), .read_addr2(ra2), .read_inst2(ri2),
    .empty(empty), .almost_empty(almost_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  function automatic void model_update();
    int np;
    bit full;
    if (flush) begin
      q.delete();
      return;
    end
    full = q.size() >= 15;
    np = re1 ? (re2 ? 2 : 1) : 0;
    if (np > q.size()) np = q.size();
    repeat (np) void'(q.pop_front());
    if (we1 && !full) begin
      q.push_back({wa1, wi1});
      if (we2) q.push_back({wa2, wi2});
    end
  endfunction

  function automatic logic [31:0] e_a1();
    return q.size() > 0 ? q[0][63:32] : 32'h0;
  endfunction
  function automatic logic [31:0] e_i1();
    return q.size() > 0 ? q[0][31:0] : 32'h0;
  endfunction
  function automatic logic [31:0] e_a2();
    return q.size() > 1 ? q[1][63:32] : 32'h0;
  endfunction
  function automatic logic [31:0] e_i2();
    return q.size() > 1 ? q[1][31:0] : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    {flush, we1, we2, re1, re2} = '0;
  endtask

  task automatic push(input logic two, input logic [31:0] a, input logic [31:0] i);
    we1 = 1; we2 = two; wa1 = a; wi1 = i; wa2 = a + 4; wi2 = ~i;
    step();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checks++;
    if (empty !== 1'b1 || almost_empty !== 1'b0 || fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got empty=%b ae=%b full=%b want 1 0 0", empty, almost_empty, fifo_full);
    end
    checks++;
    if ({ra1, ri1, ra2, ri2} !== 128'h0) begin
      failures++;
      $display("FAIL reset_read: got %h %h %h %h want zeros", ra1, ri1, ra2, ri2);
    end
    push(1, 32'h1111_0000, 32'h2222_0000);
    push(1, 32'h1111_0008, 32'h2222_0008);
    #2 rst = 1;
    #1;
    q.delete();
    checks++;
    if (empty !== 1'b1 || fifo_full !== 1'b0 || ri1 !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: got empty=%b full=%b inst1=%h want 1 0 0", empty, fifo_full, ri1);
    end
    #1 rst = 0;
  endtask

  task automatic test_pair();
    we1 = 1; we2 = 1;
    wa1 = 32'hbfc0_0000; wi1 = 32'hAAAA_AAAA;
    wa2 = 32'hbfc0_0004; wi2 = 32'hBBBB_BBBB;
    step();
    checks++;
    if (ra1 !== 32'hbfc0_0000 || ri2 !== 32'hBBBB_BBBB || empty !== 1'b0) begin
      failures++;
      $display("FAIL pair_read: got addr1=%h inst2=%h empty=%b want bfc00000 bbbbbbbb 0", ra1, ri2, empty);
    end
    checks++;
    if (ri1 !== 32'hAAAA_AAAA || ra2 !== 32'hbfc0_0004 || almost_empty !== 1'b0) begin
      failures++;
      $display("FAIL pair_other: got inst1=%h addr2=%h ae=%b want aaaaaaaa bfc00004 0", ri1, ra2, almost_empty);
    end
    re1 = 1; re2 = 1;
    step();
    checks++;
    if (empty !== 1'b1 || ra1 !== 32'h0) begin
      failures++;
      $display("FAIL pair_pop: got empty=%b addr1=%h want 1 0", empty, ra1);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 7; k++) push(1, 32'h0000_1000 + 32'(k * 8), $urandom);
    push(0, 32'h0000_1038, $urandom);
    checks++;
    if (fifo_full !== 1'b1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL full_set: got full=%b empty=%b want 1 0", fifo_full, empty);
    end
    push(1, 32'hdead_0000, 32'hdead_beef);
    checks++;
    if (fifo_full !== 1'b1 || ra1 !== e_a1()) begin
      failures++;
      $display("FAIL full_drop: got full=%b addr1=%h want 1 %h", fifo_full, ra1, e_a1());
    end
    re1 = 1; re2 = 1;
    step();
    checks++;
    if (fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL full_clear: got full=%b want 0", fifo_full);
    end
    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      checks++;
      if (ra1 !== e_a1() || ri1 !== e_i1() || ra2 !== e_a2() || ri2 !== e_i2()) begin
        failures++;
        $display("FAIL full_drain: got %h/%h %h/%h want %h/%h %h/%h",
                 ra1, ri1, ra2, ri2, e_a1(), e_i1(), e_a2(), e_i2());
      end
      re1 = 1; re2 = 1;
      step();
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL full_drained: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_single_pop();
    push(0, 32'h0000_4000, 32'h1234_5678);
    checks++;
    if (almost_empty !== 1'b1 || ri2 !== 32'h0 || ra2 !== 32'h0 || ri1 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL one_entry: got ae=%b inst2=%h addr2=%h inst1=%h want 1 0 0 12345678",
               almost_empty, ri2, ra2, ri1);
    end
    re1 = 1; re2 = 1;
    step();
    checks++;
    if (empty !== 1'b1 || almost_empty !== 1'b0) begin
      failures++;
      $display("FAIL one_pop: got empty=%b ae=%b want 1 0", empty, almost_empty);
    end
    re1 = 1; re2 = 1;
    step();
    push(1, 32'h0000_5000, 32'h5555_0000);
    checks++;
    if (ra1 !== 32'h0000_5000 || ra2 !== 32'h0000_5004) begin
      failures++;
      $display("FAIL empty_pop: got addr1=%h addr2=%h want 00005000 00005004", ra1, ra2);
    end
    re2 = 1;
    step();
    checks++;
    if (ra1 !== 32'h0000_5000) begin
      failures++;
      $display("FAIL re2_alone: got addr1=%h want 00005000", ra1);
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 60; n++) begin
      we1 = ($urandom_range(9) < 6); we2 = $urandom_range(1);
      re1 = ($urandom_range(9) < 5); re2 = $urandom_range(1);
      wa1 = $urandom & 32'hffff_fffc; wi1 = $urandom;
      wa2 = wa1 + 4; wi2 = $urandom;
      step();
      checks++;
      if (ra1 !== e_a1() || ri1 !== e_i1() || ra2 !== e_a2() || ri2 !== e_i2()) begin
        failures++;
        $display("FAIL wrap_data cyc%0d: got %h/%h %h/%h want %h/%h %h/%h",
                 n, ra1, ri1, ra2, ri2, e_a1(), e_i1(), e_a2(), e_i2());
      end
      checks++;
      if (empty !== (q.size() == 0) || almost_empty !== (q.size() == 1) || fifo_full !== (q.size() >= 15)) begin
        failures++;
        $display("FAIL wrap_flags cyc%0d: got e=%b ae=%b f=%b want count %0d",
                 n, empty, almost_empty, fifo_full, q.size());
      end
    end
  endtask

  task automatic test_flush();
    flush = 1;
    step();
    for (int k = 0; k < 3; k++) push(1, 32'h0000_6000 + 32'(k * 8), $urandom);
    flush = 1; re1 = 1; we1 = 1; we2 = 1;
    wa1 = 32'hf1f1_0000; wi1 = 32'hf1f1_f1f1; wa2 = 32'hf1f1_0004; wi2 = 32'hf2f2_f2f2;
    step();
    checks++;
    if (empty !== 1'b1 || {ra1, ri1, ra2, ri2} !== 128'h0) begin
      failures++;
      $display("FAIL flush_empty: got empty=%b %h %h %h %h want 1 zeros", empty, ra1, ri1, ra2, ri2);
    end
    push(1, 32'h0000_7000, 32'h7777_7777);
    checks++;
    if (ra1 !== 32'h0000_7000 || ri1 !== 32'h7777_7777 || ra2 !== 32'h0000_7004 || almost_empty !== 1'b0) begin
      failures++;
      $display("FAIL flush_after: got %h/%h %h ae=%b want 00007000/77777777 00007004 0",
               ra1, ri1, ra2, almost_empty);
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_full();
    test_single_pop();
    test_wrap();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
